// File: rtl/instruction_fetch_pkg.sv
// Shared uDLX fetch constants and the per-cycle fetch action encoding.
package instruction_fetch_pkg;

   localparam int unsigned PC_WIDTH_DEFAULT          = 20;
   localparam int unsigned INSTRUCTION_WIDTH_DEFAULT = 32;

   localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;
   localparam logic [19:0] RESET_PC_DEFAULT = 20'h0_0000;

   // What the fetch stage does this cycle; kill outranks hold.
   typedef enum logic [1:0] {
      ACT_NORMAL = 2'd0,
      ACT_HOLD   = 2'd1,
      ACT_KILL   = 2'd2
   } fetch_act_e;

   function automatic fetch_act_e decode_act(input logic hold, input logic kill);
      if (kill)      return ACT_KILL;
      else if (hold) return ACT_HOLD;
      else           return ACT_NORMAL;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register that catches a word returning during a hold.
module fetch_skid_buffer
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned IW = INSTRUCTION_WIDTH_DEFAULT,
   parameter int unsigned PW = PC_WIDTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_drain,
   input  logic          i_clear,
   input  logic [IW-1:0] i_instr,
   input  logic [PW-1:0] i_pc,
   output logic          o_valid,
   output logic [IW-1:0] o_instr,
   output logic [PW-1:0] o_pc
);

   logic          r_valid;
   logic [IW-1:0] r_instr;
   logic [PW-1:0] r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// uDLX fetch stage: PC, synchronous instruction-memory request and IF/ID register with skid.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int unsigned           PC_WIDTH          = PC_WIDTH_DEFAULT,
   parameter int unsigned           INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
   parameter logic [PC_WIDTH-1:0]   RESET_PC          = PC_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rd_inst_ena_in,
   input  logic                         stall_in,
   input  logic                         flush_in,
   input  logic                         select_new_pc_in,
   input  logic [PC_WIDTH-1:0]          new_pc_in,
   output logic [PC_WIDTH-1:0]          inst_mem_addr_out,
   output logic                         inst_mem_rd_en_out,
   input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
   output logic [PC_WIDTH-1:0]          pc_out,
   output logic                         inst_valid_out
);

   localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_INSTRUCTION);

   logic [PC_WIDTH-1:0]          r_pc;
   logic                         r_pending;
   logic [PC_WIDTH-1:0]          r_pending_pc;
   logic [INSTRUCTION_WIDTH-1:0] r_instr;
   logic [PC_WIDTH-1:0]          r_pc_out;
   logic                         r_valid;

   fetch_act_e                   w_act;
   logic [PC_WIDTH-1:0]          w_pc_inc;
   logic                         w_skid_valid;
   logic [INSTRUCTION_WIDTH-1:0] w_skid_instr;
   logic [PC_WIDTH-1:0]          w_skid_pc;

   always_comb begin
      w_act    = ACT_NORMAL;
      w_act    = decode_act(stall_in | ~rd_inst_ena_in, flush_in | select_new_pc_in);
      w_pc_inc = PC_WIDTH'(r_pc + PC_WIDTH'(1));
   end

   // Request is gated by reset so nothing is issued while the stage is held in reset.
   assign inst_mem_rd_en_out = rst_n & (w_act == ACT_NORMAL);
   assign inst_mem_addr_out  = r_pc;

   fetch_skid_buffer #(
      .IW (INSTRUCTION_WIDTH),
      .PW (PC_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  ((w_act == ACT_HOLD) & r_pending),
      .i_drain ((w_act == ACT_NORMAL) & w_skid_valid),
      .i_clear (w_act == ACT_KILL),
      .i_instr (inst_mem_data_in),
      .i_pc    (r_pending_pc),
      .o_valid (w_skid_valid),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_pending    <= 1'b0;
         r_pending_pc <= '0;
         r_instr      <= NOP;
         r_pc_out     <= '0;
         r_valid      <= 1'b0;
      end else begin
         case (w_act)
            ACT_KILL: begin
               if (select_new_pc_in) r_pc <= new_pc_in;
               r_pending <= 1'b0;
               r_instr   <= NOP;
               r_valid   <= 1'b0;
            end
            ACT_HOLD: begin
               r_pending <= 1'b0;
            end
            ACT_NORMAL: begin
               r_pc         <= w_pc_inc;
               r_pending    <= 1'b1;
               r_pending_pc <= w_pc_inc;
               // Skid word is older than any returning data, so it drains first.
               if (w_skid_valid) begin
                  r_instr  <= w_skid_instr;
                  r_pc_out <= w_skid_pc;
                  r_valid  <= 1'b1;
               end else if (r_pending) begin
                  r_instr  <= inst_mem_data_in;
                  r_pc_out <= r_pending_pc;
                  r_valid  <= 1'b1;
               end else begin
                  r_instr  <= NOP;
                  r_valid  <= 1'b0;
               end
            end
            default: begin
               r_pending <= 1'b0;
            end
         endcase
      end
   end

   assign instruction_out = r_instr;
   assign pc_out          = r_pc_out;
   assign inst_valid_out  = r_valid;

endmodule
